// File: rtl/ucsbece154b_issue_buffer.sv
// Dual-issue instruction buffer: a circular FIFO that accepts fetch pairs and presents two decode slots.
// Optional same-cycle bypass from fetch to the slots when empty: define ISSUE_BUFFER_BYPASS_EN.
module ucsbece154b_issue_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     FetchValid_i,
  input  logic                     FetchValid1_i,
  input  logic [31:0]              FetchInstr0_i,
  input  logic [31:0]              FetchInstr1_i,
  input  logic [31:0]              FetchPC_i,
  output logic                     FetchReady_o,
  output logic                     Slot1Valid_o,
  output logic                     Slot2Valid_o,
  output logic [31:0]              Slot1Instr_o,
  output logic [31:0]              Slot2Instr_o,
  output logic [31:0]              Slot1PC_o,
  output logic [31:0]              Slot2PC_o,
  input  logic                     StallD_i,
  input  logic                     IssueSlot2_i,
  input  logic                     Flush_i,
  output logic [$clog2(DEPTH):0]   Count_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;

  logic [AW:0]     w_free;
  logic            w_ready;
  logic            w_push;
  logic [1:0]      w_push_n;
  logic [1:0]      w_pop;
  logic [1:0]      w_skip;
  logic            w_s1_valid;
  logic            w_s2_valid;
  entry_t          w_s1;
  entry_t          w_s2;
  entry_t          w_in0;
  entry_t          w_in1;
  logic            w_wr0;
  logic            w_wr1;
  logic [AW-1:0]   w_wr1_idx;

  // Readiness looks only at registered occupancy, so a pop in this cycle never frees room early.
  assign w_free   = DEPTH_C - r_count;
  assign w_ready  = (w_free >= (AW+1)'(2));
  assign w_push   = FetchValid_i & w_ready & ~Flush_i;
  assign w_push_n = w_push ? (FetchValid1_i ? 2'd2 : 2'd1) : 2'd0;

  assign w_in0 = '{instr: FetchInstr0_i, pc: FetchPC_i};
  assign w_in1 = '{instr: FetchInstr1_i, pc: FetchPC_i + 32'd4};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_s1_valid = (r_count >= (AW+1)'(1));
    w_s2_valid = (r_count >= (AW+1)'(2));
    w_s1       = r_mem[r_head];
    w_s2       = r_mem[r_head + AW'(1)];
`ifdef ISSUE_BUFFER_BYPASS_EN
    if (w_push && (r_count == '0)) begin
      w_s1_valid = 1'b1;
      w_s2_valid = FetchValid1_i;
      w_s1       = w_in0;
      w_s2       = w_in1;
    end
`endif
  end

  assign w_pop = StallD_i ? 2'd0
                          : ({1'b0, w_s1_valid} + {1'b0, w_s2_valid & IssueSlot2_i});

  // Bypassed instructions that issue immediately are never stored; w_skip counts them.
`ifdef ISSUE_BUFFER_BYPASS_EN
  assign w_skip = (w_push && (r_count == '0)) ? w_pop : 2'd0;
`else
  assign w_skip = 2'd0;
`endif

  assign w_wr0     = w_push & (w_skip == 2'd0);
  assign w_wr1     = w_push & FetchValid1_i & (w_skip != 2'd2);
  assign w_wr1_idx = (w_skip == 2'd0) ? (r_tail + AW'(1)) : r_tail;

  // NOTE: the storage array carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_wr0) r_mem[r_tail]    <= w_in0;
    if (w_wr1) r_mem[w_wr1_idx] <= w_in1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop - w_skip);
      r_tail  <= r_tail + AW'(w_push_n - w_skip);
      r_count <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
    end
  end

  assign FetchReady_o = w_ready;
  assign Count_o      = r_count;
  assign Slot1Valid_o = w_s1_valid;
  assign Slot2Valid_o = w_s2_valid;
  assign Slot1Instr_o = w_s1_valid ? w_s1.instr : NOP;
  assign Slot1PC_o    = w_s1_valid ? w_s1.pc    : 32'd0;
  assign Slot2Instr_o = w_s2_valid ? w_s2.instr : NOP;
  assign Slot2PC_o    = w_s2_valid ? w_s2.pc    : 32'd0;

endmodule

// File: tb/tb_ucsbece154b_issue_buffer.sv
// Self-checking bench for ucsbece154b_issue_buffer (DEPTH=8) against a queue-based reference model.
// Bypass expectations are enabled by defining ISSUE_BUFFER_BYPASS_EN for both bench and design.
module tb_ucsbece154b_issue_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fv, fv1, stall, iss2, flush;
  logic [31:0] i0, i1, pc;
  logic        ready, s1v, s2v;
  logic [31:0] s1i, s2i, s1pc, s2pc;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          order_chk = 0;
  logic [31:0] seq_pc;

  ucsbece154b_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .FetchValid_i(fv), .FetchValid1_i(fv1),
    .FetchInstr0_i(i0), .FetchInstr1_i(i1), .FetchPC_i(pc),
    .FetchReady_o(ready),
    .Slot1Valid_o(s1v), .Slot2Valid_o(s2v),
    .Slot1Instr_o(s1i), .Slot2Instr_o(s2i),
    .Slot1PC_o(s1pc), .Slot2PC_o(s2pc),
    .StallD_i(stall), .IssueSlot2_i(iss2), .Flush_i(flush),
    .Count_o(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic v1, input logic [31:0] p,
                       input logic st, input logic is2, input logic fl);
    fv = v; fv1 = v1; pc = p; stall = st; iss2 = is2; flush = fl;
    i0 = $urandom; i1 = $urandom;
  endtask

  // Predict outputs from the queue, compare, then advance the queue by this cycle's rules.
  task automatic model_step(input string tag);
    bit   push, byp, ex_ready;
    int   npop;
    ent_t pushed[$];
    ent_t view[$];
    ex_ready = (DEPTH - q.size()) >= 2;
    push     = fv && ex_ready && !flush;
    if (push) begin
      pushed.push_back('{instr: i0, pc: pc});
      if (fv1) pushed.push_back('{instr: i1, pc: pc + 32'd4});
    end
`ifdef ISSUE_BUFFER_BYPASS_EN
    byp = push && (q.size() == 0);
`else
    byp = 0;
`endif
    view = byp ? pushed : q;
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".ready"}, 32'(ready), 32'(ex_ready));
    check({tag, ".s1v"},   32'(s1v),   32'(view.size() >= 1));
    check({tag, ".s2v"},   32'(s2v),   32'(view.size() >= 2));
    check({tag, ".s1i"},   s1i,  view.size() >= 1 ? view[0].instr : NOP);
    check({tag, ".s1pc"},  s1pc, view.size() >= 1 ? view[0].pc    : 32'd0);
    check({tag, ".s2i"},   s2i,  view.size() >= 2 ? view[1].instr : NOP);
    check({tag, ".s2pc"},  s2pc, view.size() >= 2 ? view[1].pc    : 32'd0);
    if (flush) begin
      q.delete();
    end else begin
      npop = stall ? 0 : ((view.size() >= 1 ? 1 : 0) + ((view.size() >= 2 && iss2) ? 1 : 0));
      if (order_chk && npop >= 1) begin
        check({tag, ".order1"}, s1pc, seq_pc);
        seq_pc += 4;
        if (npop == 2) begin
          check({tag, ".order2"}, s2pc, seq_pc);
          seq_pc += 4;
        end
      end
      for (int k = 0; k < npop; k++) void'(view.pop_front());
      if (!byp) foreach (pushed[k]) view.push_back(pushed[k]);
      q = view;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step(input string tag);
    model_step(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(input string tag);
    settle();
    step(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    check("rst.count", 32'(count), 0);
    check("rst.ready", 32'(ready), 1);
    check("rst.s1v",   32'(s1v),   0);
    check("rst.s2v",   32'(s2v),   0);
    check("rst.s1i",   s1i, NOP);
    check("rst.s2i",   s2i, NOP);
    check("rst.s1pc",  s1pc, 0);
    check("rst.s2pc",  s2pc, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Pair at 0x100 issues as a pair one cycle later, then the buffer is empty.
    drive(1, 1, 32'h100, 0, 1, 0);
    tick("pair.push");
    drive(0, 0, 0, 0, 1, 0);
    settle();
`ifndef ISSUE_BUFFER_BYPASS_EN
    check("pair.s1pc", s1pc, 32'h100);
    check("pair.s2pc", s2pc, 32'h104);
    check("pair.cnt2", 32'(count), 2);
`endif
    step("pair.issue");
    settle();
    check("pair.empty", 32'(count), 0);
    step("pair.idle");

    // Fill under stall: full buffer refuses further pairs.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h300 + 32'(8 * k), 1, 1, 0);
      tick("fill");
    end
    drive(1, 1, 32'h380, 1, 1, 0);
    settle();
    check("full.count", 32'(count), 8);
    check("full.ready", 32'(ready), 0);
    step("full.ignored");
    settle();
    check("full.hold", 32'(count), 8);
    drive(0, 0, 0, 0, 0, 1);
    tick("full.flush");

    // Three entries, slot 2 held back: one issue per cycle.
    drive(1, 1, 32'h400, 1, 0, 0);
    tick("three.a");
    drive(1, 0, 32'h408, 1, 0, 0);
    tick("three.b");
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("three.count", 32'(count), 32'(3 - k));
      if (k < 3) check("three.s1pc", s1pc, 32'h400 + 32'(4 * k));
      step("three.drain");
    end

    // Flush with six buffered and a simultaneous push.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h500 + 32'(8 * k), 1, 0, 0);
      tick("six.fill");
    end
    settle();
    check("six.count", 32'(count), 6);
    drive(1, 1, 32'h600, 0, 1, 1);
    tick("six.flush");
    drive(0, 0, 0, 0, 0, 0);
    settle();
    check("flush.count", 32'(count), 0);
    check("flush.s1i",   s1i, NOP);
    check("flush.s2i",   s2i, NOP);
    check("flush.s1pc",  s1pc, 0);
    step("flush.after");

    // Streaming across pointer wrap: PCs must issue in strict order.
    order_chk = 1;
    seq_pc    = 32'h1000;
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 32'h1000 + 32'(8 * k), 0, 1, 0);
      tick("wrap");
    end
    drive(0, 0, 0, 0, 1, 0);
    tick("wrap.drain");
    tick("wrap.drain");
    check("wrap.all", seq_pc, 32'h1000 + 32'(20 * 8));
    order_chk = 0;

    // Asynchronous reset mid-operation discards contents.
    drive(1, 1, 32'h700, 1, 0, 0);
    tick("mid.fill");
    tick("mid.fill");
    reset = 1'b0;
    #1;
    q.delete();
    check("mid.count", 32'(count), 0);
    check("mid.ready", 32'(ready), 1);
    check("mid.s1v",   32'(s1v),   0);
    check("mid.s1i",   s1i, NOP);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick("mid.after");

`ifdef ISSUE_BUFFER_BYPASS_EN
    // Empty buffer: a fetched pair reaches both slots in the same cycle.
    drive(1, 1, 32'h200, 0, 1, 0);
    settle();
    check("byp.s1pc", s1pc, 32'h200);
    check("byp.s2pc", s2pc, 32'h204);
    check("byp.s1v",  32'(s1v), 1);
    step("byp.push");
    drive(0, 0, 0, 0, 1, 0);
    settle();
    check("byp.count", 32'(count), 0);
    step("byp.after");
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            {$urandom_range(0, 65535), 2'b00} << 2,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
